// File: rtl/riscv_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
package riscv_loader_pkg;

    localparam int LEN_W  = 16;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;

    localparam logic [BYTE_W-1:0] MAGIC = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN0  = 3'd1,
        ST_LEN1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4,
        ST_CSUM  = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERR   = 3'd7
    } loader_state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    // Loader side: consumes the stream, drives the memory write port.
    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    // Environment side: produces the stream, observes the memory writes.
    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );
endinterface

// File: rtl/imem_loader_byte_word_packer.sv
// Assembles little-endian 32-bit words from a byte stream and keeps a
// running XOR of every byte shifted in.
module byte_word_packer
    import riscv_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic [1:0]        lane,
    output logic [BYTE_W-1:0] csum
);

    logic [WORD_W-1:0] word_q, word_d;
    logic [1:0]        lane_q, lane_d;
    logic [BYTE_W-1:0] csum_q, csum_d;

    // Next-state: clear wins, otherwise drop the byte into its lane.
    always_comb begin
        word_d = word_q;
        lane_d = lane_q;
        csum_d = csum_q;
        if (clear) begin
            word_d = 32'h0000_0000;
            lane_d = 2'd0;
            csum_d = 8'h00;
        end else if (shift_en) begin
            case (lane_q)
                2'd0:    word_d[7:0]   = byte_in;
                2'd1:    word_d[15:8]  = byte_in;
                2'd2:    word_d[23:16] = byte_in;
                default: word_d[31:24] = byte_in;
            endcase
            lane_d = lane_q + 2'd1;
            csum_d = csum_q ^ byte_in;
        end else begin
            word_d = word_q;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_q <= 32'h0000_0000;
            lane_q <= 2'd0;
            csum_q <= 8'h00;
        end else begin
            word_q <= word_d;
            lane_q <= lane_d;
            csum_q <= csum_d;
        end
    end

    assign word = word_q;
    assign lane = lane_q;
    assign csum = csum_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a framed program over a byte stream, writes it into
// instruction memory and releases the core only after the checksum matches.
module imem_loader #(
    parameter int         IMEM_DEPTH = 256,
    parameter int         ADDR_W     = 32,
    parameter logic [7:0] MAGIC      = riscv_loader_pkg::MAGIC
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.master bus,
    output logic          core_reset,
    output logic          done,
    output logic          err
);
    import riscv_loader_pkg::*;

    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(IMEM_DEPTH);

    loader_state_t     state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  word_idx_q, word_idx_d;
    logic              in_ready_q, in_ready_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [WORD_W-1:0] imem_wdata_q, imem_wdata_d;
    logic              core_reset_q, core_reset_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept_s;
    logic              pk_clear_s;
    logic              pk_shift_s;
    logic [WORD_W-1:0] pk_word_s;
    logic [1:0]        pk_lane_s;
    logic [BYTE_W-1:0] pk_csum_s;
    logic [LEN_W-1:0]  len_full_s;
    logic [LEN_W-1:0]  word_idx_inc_s;

    assign accept_s       = bus.in_valid && in_ready_q;
    assign len_full_s     = {bus.in_data, len_lo_q};
    assign word_idx_inc_s = word_idx_q + 16'd1;

    byte_word_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .clear    (pk_clear_s),
        .shift_en (pk_shift_s),
        .byte_in  (bus.in_data),
        .word     (pk_word_s),
        .lane     (pk_lane_s),
        .csum     (pk_csum_s)
    );

    // Frame-parsing FSM: next state and next registered outputs.
    always_comb begin
        state_d      = state_q;
        len_lo_d     = len_lo_q;
        len_d        = len_q;
        word_idx_d   = word_idx_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        core_reset_d = core_reset_q;
        done_d       = done_q;
        err_d        = err_q;
        pk_clear_s   = 1'b0;
        pk_shift_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && (bus.in_data == MAGIC)) begin
                    state_d = ST_LEN0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LEN0: begin
                if (accept_s) begin
                    len_lo_d = bus.in_data;
                    state_d  = ST_LEN1;
                end else begin
                    state_d = ST_LEN0;
                end
            end
            ST_LEN1: begin
                if (accept_s) begin
                    len_d      = len_full_s;
                    word_idx_d = 16'd0;
                    pk_clear_s = 1'b1;
                    if (len_full_s > DEPTH_L) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                        done_d  = 1'b0;
                    end else if (len_full_s == 16'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_LEN1;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
                    pk_shift_s = 1'b1;
                    if (pk_lane_s == 2'd3) begin
                        // Last byte is still on the bus; splice it in here.
                        state_d      = ST_WRITE;
                        imem_we_d    = 1'b1;
                        imem_addr_d  = ADDR_W'({word_idx_q, 2'b00});
                        imem_wdata_d = {bus.in_data, pk_word_s[23:0]};
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_WRITE: begin
                word_idx_d = word_idx_inc_s;
                if (word_idx_inc_s == len_q) begin
                    state_d = ST_CSUM;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_CSUM: begin
                if (accept_s) begin
                    if (bus.in_data == pk_csum_s) begin
                        state_d      = ST_DONE;
                        core_reset_d = 1'b0;
                        done_d       = 1'b1;
                        err_d        = 1'b0;
                    end else begin
                        state_d      = ST_ERR;
                        core_reset_d = 1'b1;
                        done_d       = 1'b0;
                        err_d        = 1'b1;
                    end
                end else begin
                    state_d = ST_CSUM;
                end
            end
            ST_DONE: begin
                if (accept_s && (bus.in_data == MAGIC)) begin
                    state_d      = ST_LEN0;
                    core_reset_d = 1'b1;
                    done_d       = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_ERR: begin
                core_reset_d = 1'b1;
                if (accept_s && (bus.in_data == MAGIC)) begin
                    state_d = ST_LEN0;
                    err_d   = 1'b0;
                end else begin
                    state_d = ST_ERR;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                core_reset_d = 1'b1;
                done_d       = 1'b0;
                err_d        = 1'b0;
            end
        endcase
        // The stream stalls only for the single memory-write cycle.
        in_ready_d = (state_d != ST_WRITE);
    end

    // FSM state and registered outputs, asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            len_lo_q     <= 8'h00;
            len_q        <= 16'd0;
            word_idx_q   <= 16'd0;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'h0000_0000;
            core_reset_q <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            len_q        <= len_d;
            word_idx_q   <= word_idx_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign core_reset     = core_reset_q;
    assign done           = done_q;
    assign err            = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of frames plus hand-written
// abort, restart and flow-control sequences.
module tb_imem_loader;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic core_reset, done, err;

    imem_loader_if #(.ADDR_W(32)) bus ();

    imem_loader #(.IMEM_DEPTH(256), .ADDR_W(32), .MAGIC(8'hA5)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .core_reset (core_reset),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int ready_during_we = 0;
    int we_seen = 0;
    logic [31:0] wlog_addr[$];
    logic [31:0] wlog_data[$];

    typedef struct {
        logic [0:15][7:0] b;
        int               n;
        int               nw;
        logic [31:0]      w0;
        logic [31:0]      w1;
        logic             dn;
        logic             er;
        logic             cr;
    } vec_t;

    vec_t vecs[6];

    // Log every memory write and note any write cycle that still accepts bytes.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wlog_addr.push_back(bus.imem_addr);
            wlog_data.push_back(bus.imem_wdata);
            we_seen++;
            if (bus.in_ready !== 1'b0) ready_during_we++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            n_checks++;
            $display("FAIL send_timeout: in_ready=%b expected 1", bus.in_ready);
        end else begin
            bus.in_valid = 1'b1;
            bus.in_data  = b;
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
        end
    endtask

    task automatic clear_log();
        wlog_addr.delete();
        wlog_data.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},   {31'd0, bus.in_ready}, 32'd0);
        chk({tag, "_imem_we"},    {31'd0, bus.imem_we},  32'd0);
        chk({tag, "_imem_addr"},  bus.imem_addr,         32'd0);
        chk({tag, "_imem_wdata"}, bus.imem_wdata,        32'd0);
        chk({tag, "_core_reset"}, {31'd0, core_reset},   32'd1);
        chk({tag, "_done"},       {31'd0, done},         32'd0);
        chk({tag, "_err"},        {31'd0, err},          32'd0);
    endtask

    // Frame B: words 0x00500E13, 0x00100E93, checksum 0xC0.
    logic [7:0] frame_b[12];

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        vecs[0] = '{b: {8'hA5,8'h02,8'h00,8'h13,8'h0E,8'h50,8'h00,8'h93,8'h0E,8'h10,8'h00,8'hC0,8'h00,8'h00,8'h00,8'h00},
                    n: 12, nw: 2, w0: 32'h00500E13, w1: 32'h00100E93, dn: 1'b1, er: 1'b0, cr: 1'b0};
        vecs[1] = '{b: {8'hA5,8'h02,8'h00,8'h13,8'h0E,8'h50,8'h00,8'h93,8'h0E,8'h10,8'h00,8'hC1,8'h00,8'h00,8'h00,8'h00},
                    n: 12, nw: 2, w0: 32'h00500E13, w1: 32'h00100E93, dn: 1'b0, er: 1'b1, cr: 1'b1};
        vecs[2] = '{b: {8'hA5,8'h01,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                    n: 3, nw: 0, w0: 32'h0, w1: 32'h0, dn: 1'b0, er: 1'b1, cr: 1'b1};
        vecs[3] = '{b: {8'hA5,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                    n: 4, nw: 0, w0: 32'h0, w1: 32'h0, dn: 1'b1, er: 1'b0, cr: 1'b0};
        vecs[4] = '{b: {8'hA5,8'h00,8'h00,8'hFF,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                    n: 4, nw: 0, w0: 32'h0, w1: 32'h0, dn: 1'b0, er: 1'b1, cr: 1'b1};
        vecs[5] = '{b: {8'hA5,8'h01,8'h00,8'hEF,8'hBE,8'hAD,8'hDE,8'h22,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
                    n: 8, nw: 1, w0: 32'hDEADBEEF, w1: 32'h0, dn: 1'b1, er: 1'b0, cr: 1'b0};

        frame_b = '{8'hA5,8'h02,8'h00,8'h13,8'h0E,8'h50,8'h00,8'h93,8'h0E,8'h10,8'h00,8'hC0};

        // Reset state while reset is held low.
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;

        // Table-driven frames.
        for (int v = 0; v < 6; v++) begin
            clear_log();
            for (int i = 0; i < vecs[v].n; i++) send_byte(vecs[v].b[i]);
            repeat (2) @(negedge clk);
            chk($sformatf("v%0d_nwrites", v), wlog_addr.size(), vecs[v].nw);
            if (wlog_addr.size() >= 1 && vecs[v].nw >= 1) begin
                chk($sformatf("v%0d_addr0", v), wlog_addr[0], 32'h0);
                chk($sformatf("v%0d_data0", v), wlog_data[0], vecs[v].w0);
            end
            if (wlog_addr.size() >= 2 && vecs[v].nw >= 2) begin
                chk($sformatf("v%0d_addr1", v), wlog_addr[1], 32'h4);
                chk($sformatf("v%0d_data1", v), wlog_data[1], vecs[v].w1);
            end
            chk($sformatf("v%0d_done", v),       {31'd0, done},       {31'd0, vecs[v].dn});
            chk($sformatf("v%0d_err", v),        {31'd0, err},        {31'd0, vecs[v].er});
            chk($sformatf("v%0d_core_reset", v), {31'd0, core_reset}, {31'd0, vecs[v].cr});
        end

        // Abort: reset asserted after 6 data bytes of a 2-word frame.
        for (int i = 0; i < 9; i++) send_byte(frame_b[i]);
        reset = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        reset = 1'b1;
        clear_log();
        for (int i = 0; i < vecs[5].n; i++) send_byte(vecs[5].b[i]);
        repeat (2) @(negedge clk);
        chk("abort_nwrites", wlog_addr.size(), 1);
        if (wlog_addr.size() >= 1) begin
            chk("abort_addr0", wlog_addr[0], 32'h0);
            chk("abort_data0", wlog_data[0], 32'hDEADBEEF);
        end
        chk("abort_done", {31'd0, done}, 32'd1);
        chk("abort_core_reset", {31'd0, core_reset}, 32'd0);

        // Restart from DONE: garbage ignored, MAGIC reasserts core reset.
        send_byte(8'h11);
        @(negedge clk);
        chk("garbage_done", {31'd0, done}, 32'd1);
        chk("garbage_core_reset", {31'd0, core_reset}, 32'd0);
        send_byte(8'hA5);
        chk("restart_core_reset", {31'd0, core_reset}, 32'd1);
        chk("restart_done", {31'd0, done}, 32'd0);

        // Remainder of the frame with random gaps on in_valid.
        clear_log();
        for (int i = 1; i < 12; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_byte(frame_b[i]);
        end
        repeat (2) @(negedge clk);
        chk("gap_nwrites", wlog_addr.size(), 2);
        if (wlog_addr.size() >= 2) begin
            chk("gap_addr0", wlog_addr[0], 32'h0);
            chk("gap_data0", wlog_data[0], 32'h00500E13);
            chk("gap_addr1", wlog_addr[1], 32'h4);
            chk("gap_data1", wlog_data[1], 32'h00100E93);
        end
        chk("gap_done", {31'd0, done}, 32'd1);
        chk("gap_err", {31'd0, err}, 32'd0);
        chk("gap_core_reset", {31'd0, core_reset}, 32'd0);

        // in_ready must be low in every write cycle observed in the run.
        chk("ready_low_in_write", ready_during_we, 0);
        chk("writes_observed", {31'd0, (we_seen >= 8)}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
